// File: rtl/flag_branch_ctrl_if.sv
// ----------------------------------------------------------------------------
// flag_branch_ctrl_if
// Purpose : bundles the EX-stage flag-update signals and the decode-stage
//           branch handshake that connect to flag_branch_ctrl.
// Signals :
//   ex_valid/ex_opcode/ex_result/ex_ovfl/ex_ready  EX-stage ALU outputs
//   stall/flush                                    pipeline control
//   br_req/br_cond                                 branch request from decode
//   br_wait/br_done/br_taken                       branch handshake to decode
//   flags                                          architectural {N,V,Z}
// Modports: master drives the EX/decode side, slave is flag_branch_ctrl.
// ----------------------------------------------------------------------------
interface flag_branch_ctrl_if #(
   parameter int OPC_W  = 4,
   parameter int DATA_W = 16
);
   logic              ex_valid;
   logic [OPC_W-1:0]  ex_opcode;
   logic [DATA_W-1:0] ex_result;
   logic              ex_ovfl;
   logic              ex_ready;
   logic              stall;
   logic              flush;
   logic              br_req;
   logic [2:0]        br_cond;
   logic              br_wait;
   logic              br_done;
   logic              br_taken;
   logic [2:0]        flags;

   modport master (
      output ex_valid, ex_opcode, ex_result, ex_ovfl, ex_ready,
      output stall, flush, br_req, br_cond,
      input  br_wait, br_done, br_taken, flags
   );

   modport slave (
      input  ex_valid, ex_opcode, ex_result, ex_ovfl, ex_ready,
      input  stall, flush, br_req, br_cond,
      output br_wait, br_done, br_taken, flags
   );
endinterface

// File: rtl/flag_branch_ctrl.sv
// ----------------------------------------------------------------------------
// flag_branch_ctrl
// Purpose : owns the {N,V,Z} FLAG register, commits per-opcode flag updates
//           from the EX stage, and resolves conditional branches for decode,
//           holding decode (br_wait) while the flags a branch depends on are
//           not yet final.
// Ports   :
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - flag_branch_ctrl_if.slave (EX inputs, branch handshake, flags)
// Config  : FLAG_BYPASS_EN
//   defined   - a branch may resolve in the same cycle as the flag commit,
//               evaluating on the next-state flags.
//   undefined - any flag-setting EX instruction blocks the branch, which then
//               evaluates on the stored flags after the commit.
// ----------------------------------------------------------------------------
module flag_branch_ctrl #(
   parameter int OPC_W  = 4,
   parameter int DATA_W = 16
) (
   input logic               clk,
   input logic               rst,
   flag_branch_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] flags_q, flags_d;
   logic       br_taken_q, br_taken_d;

   logic       setsNvz;
   logic       setsZ;
   logic       setsFlags;
   logic       commit;
   logic       hazard;
   logic [2:0] flagsUpd;
   logic [2:0] evalFlags;
   logic       condTrue;
   logic       isUncond;
   logic       brWait;

   // ADD/SUB update all three flags; logic/shift ops update only Z.
   always_comb begin
      setsNvz = 1'b0;
      setsZ   = 1'b0;
      case (bus.ex_opcode)
         OPC_W'(4'b0000), OPC_W'(4'b0001): begin
            setsNvz = 1'b1;
            setsZ   = 1'b1;
         end
         OPC_W'(4'b0010), OPC_W'(4'b0100),
         OPC_W'(4'b0101), OPC_W'(4'b0110): begin
            setsZ = 1'b1;
         end
         default: begin
            setsNvz = 1'b0;
            setsZ   = 1'b0;
         end
      endcase
   end

   assign setsFlags = setsZ;
   assign commit    = bus.ex_valid & bus.ex_ready & setsFlags & ~bus.stall & ~bus.flush;

   // Bits an opcode does not own keep their stored value.
   assign flagsUpd[2] = setsNvz ? bus.ex_result[DATA_W-1] : flags_q[2];
   assign flagsUpd[1] = setsNvz ? bus.ex_ovfl : flags_q[1];
   assign flagsUpd[0] = setsZ ? (bus.ex_result == '0) : flags_q[0];
   assign flags_d     = commit ? flagsUpd : flags_q;

`ifdef FLAG_BYPASS_EN
   // Only an unfinished or stalled flag-setter blocks; a result committing
   // this cycle is forwarded through flags_d.
   assign hazard    = bus.ex_valid & setsFlags & (~bus.ex_ready | bus.stall);
   assign evalFlags = flags_d;
`else
   // Without forwarding, wait until the flag-setter has left EX entirely.
   assign hazard    = bus.ex_valid & setsFlags;
   assign evalFlags = flags_q;
`endif

   function automatic logic evalCond(input logic [2:0] cond, input logic [2:0] f);
      logic n, v, z;
      n = f[2];
      v = f[1];
      z = f[0];
      case (cond)
         3'b000:  evalCond = ~z;
         3'b001:  evalCond = z;
         3'b010:  evalCond = ~z & ~n;
         3'b011:  evalCond = n;
         3'b100:  evalCond = z | ~n;
         3'b101:  evalCond = n | z;
         3'b110:  evalCond = v;
         default: evalCond = 1'b1;
      endcase
   endfunction

   assign condTrue = evalCond(bus.br_cond, evalFlags);
   assign isUncond = (bus.br_cond == 3'b111);

   // Branch FSM next state. br_wait drops in the cycle the branch resolves,
   // so decode is held only while the flags are genuinely not yet usable.
   always_comb begin
      state_d    = state_q;
      br_taken_d = br_taken_q;
      brWait     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.br_req && !bus.flush) begin
               if (isUncond || !hazard) begin
                  state_d    = ST_DONE;
                  br_taken_d = condTrue;
               end else begin
                  brWait  = 1'b1;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (bus.flush) begin
               state_d = ST_IDLE;
            end else if (!hazard && !bus.stall) begin
               state_d    = ST_DONE;
               br_taken_d = condTrue;
            end else begin
               brWait = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         flags_q    <= 3'b000;
         br_taken_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         flags_q    <= flags_d;
         br_taken_q <= br_taken_d;
      end
   end

   // br_wait is combinational from br_req, so it is forced low during reset
   // to keep every output quiet while rst is asserted.
   assign bus.br_wait  = brWait & ~rst;
   assign bus.br_done  = (state_q == ST_DONE);
   assign bus.br_taken = br_taken_q;
   assign bus.flags    = flags_q;

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_flag_branch_ctrl
// Purpose : directed self-checking bench for flag_branch_ctrl. Expected
//           br_wait/br_done timing differs with FLAG_BYPASS_EN.
// ----------------------------------------------------------------------------
module tb_flag_branch_ctrl;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_XOR    = 4'b0010;
   localparam logic [3:0] OP_RED    = 4'b0011;
   localparam logic [3:0] OP_SLL    = 4'b0100;
   localparam logic [3:0] OP_PADDSB = 4'b0111;

   logic clk;
   logic rst;
   int   testsRun;
   int   testsFailed;

   flag_branch_ctrl_if #(.OPC_W(4), .DATA_W(16)) bus ();

   flag_branch_ctrl #(.OPC_W(4), .DATA_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns all inputs to an inactive state.
   task automatic clearInputs();
      bus.ex_valid  = 1'b0;
      bus.ex_opcode = 4'b0000;
      bus.ex_result = 16'h0000;
      bus.ex_ovfl   = 1'b0;
      bus.ex_ready  = 1'b0;
      bus.stall     = 1'b0;
      bus.flush     = 1'b0;
      bus.br_req    = 1'b0;
      bus.br_cond   = 3'b000;
   endtask

   // Presents one single-cycle EX op, then removes it after the edge.
   task automatic applyOp(input logic [3:0] opc, input logic [15:0] res,
                          input logic ovfl, input logic stallV, input logic flushV);
      @(negedge clk);
      bus.ex_valid  = 1'b1;
      bus.ex_opcode = opc;
      bus.ex_result = res;
      bus.ex_ovfl   = ovfl;
      bus.ex_ready  = 1'b1;
      bus.stall     = stallV;
      bus.flush     = flushV;
      @(negedge clk);
      bus.ex_valid  = 1'b0;
      bus.stall     = 1'b0;
      bus.flush     = 1'b0;
   endtask

   task automatic checkFlags(input string name, input logic [2:0] exp);
      testsRun++;
      if (bus.flags !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: flags got %b expected %b", name, bus.flags, exp);
      end
   endtask

   task automatic test_reset();
      clearInputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      testsRun += 4;
      if (bus.flags !== 3'b000) begin
         testsFailed++;
         $display("[TB] FAIL reset_flags: got %b expected 000", bus.flags);
      end
      if (bus.br_wait !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_br_wait: got %b expected 0", bus.br_wait);
      end
      if (bus.br_done !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_br_done: got %b expected 0", bus.br_done);
      end
      if (bus.br_taken !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_br_taken: got %b expected 0", bus.br_taken);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_flag_update();
      applyOp(OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b0);
      checkFlags("add_zero", 3'b001);
      applyOp(OP_SUB, 16'h8000, 1'b1, 1'b0, 1'b0);
      checkFlags("sub_neg_ovfl", 3'b110);
      applyOp(OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b0);
      applyOp(OP_XOR, 16'h1234, 1'b1, 1'b0, 1'b0);
      checkFlags("xor_nonzero", 3'b000);
      applyOp(OP_RED, 16'h0000, 1'b1, 1'b0, 1'b0);
      checkFlags("red_no_update", 3'b000);
      applyOp(OP_SUB, 16'h8000, 1'b1, 1'b0, 1'b0);
      applyOp(OP_XOR, 16'h0000, 1'b0, 1'b0, 1'b0);
      checkFlags("xor_zero_holds_nv", 3'b111);
      applyOp(OP_PADDSB, 16'h0001, 1'b0, 1'b0, 1'b0);
      checkFlags("paddsb_no_update", 3'b111);
      applyOp(OP_SLL, 16'h8001, 1'b0, 1'b0, 1'b0);
      checkFlags("sll_clears_z_only", 3'b110);
      applyOp(OP_ADD, 16'h0000, 1'b0, 1'b1, 1'b0);
      checkFlags("stall_blocks_commit", 3'b110);
   endtask

   // One no-hazard branch: done the cycle after request, never waits.
   task automatic doBranch(input logic [2:0] cond, input logic expTaken);
      @(negedge clk);
      bus.br_req  = 1'b1;
      bus.br_cond = cond;
      #1;
      testsRun++;
      if (bus.br_wait !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL br_wait_cond%0d: got %b expected 0", cond, bus.br_wait);
      end
      @(posedge clk);
      #1;
      testsRun += 2;
      if (bus.br_done !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL br_done_cond%0d: got %b expected 1", cond, bus.br_done);
      end
      if (bus.br_taken !== expTaken) begin
         testsFailed++;
         $display("[TB] FAIL br_taken_cond%0d: got %b expected %b flags=%b",
                  cond, bus.br_taken, expTaken, bus.flags);
      end
      @(negedge clk);
      bus.br_req = 1'b0;
      @(posedge clk);
      #1;
      testsRun++;
      if (bus.br_done !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL br_done_pulse_cond%0d: got %b expected 0", cond, bus.br_done);
      end
   endtask

   task automatic test_conditions();
      logic [7:0] expTab;
      applyOp(OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b0);
      checkFlags("cond_setup_z", 3'b001);
      expTab = 8'b1011_0010;
      for (int c = 0; c < 8; c++) doBranch(3'(c), expTab[c]);
      applyOp(OP_SUB, 16'h8000, 1'b1, 1'b0, 1'b0);
      checkFlags("cond_setup_nv", 3'b110);
      expTab = 8'b1110_1001;
      for (int c = 0; c < 8; c++) doBranch(3'(c), expTab[c]);
   endtask

   // Multi-cycle ADD (ready low 3 cycles, result 0xFFFF) under a LT branch.
   task automatic test_multicycle();
      int  waitCnt;
      int  doneCyc;
      logic taken;
`ifdef FLAG_BYPASS_EN
      int  expWait = 3;
      int  expDone = 3;
`else
      int  expWait = 4;
      int  expDone = 4;
`endif
      applyOp(OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b0);
      waitCnt = 0;
      doneCyc = -1;
      taken   = 1'b0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         bus.br_req    = 1'b1;
         bus.br_cond   = 3'b011;
         bus.ex_opcode = OP_ADD;
         bus.ex_ovfl   = 1'b0;
         bus.ex_valid  = (cyc <= 3);
         bus.ex_ready  = (cyc == 3);
         bus.ex_result = (cyc == 3) ? 16'hFFFF : 16'h0000;
         #1;
         if (bus.br_wait === 1'b1) waitCnt++;
         @(posedge clk);
         #1;
         if (bus.br_done === 1'b1) begin
            doneCyc = cyc;
            taken   = bus.br_taken;
            break;
         end
      end
      @(negedge clk);
      clearInputs();
      testsRun += 4;
      if (waitCnt != expWait) begin
         testsFailed++;
         $display("[TB] FAIL mc_wait_cycles: got %0d expected %0d", waitCnt, expWait);
      end
      if (doneCyc != expDone) begin
         testsFailed++;
         $display("[TB] FAIL mc_done_cycle: got %0d expected %0d", doneCyc, expDone);
      end
      if (taken !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL mc_taken: got %b expected 1", taken);
      end
      if (bus.flags !== 3'b100) begin
         testsFailed++;
         $display("[TB] FAIL mc_flags: got %b expected 100", bus.flags);
      end
   endtask

   task automatic test_flush();
      @(negedge clk);
      bus.ex_valid  = 1'b1;
      bus.ex_opcode = OP_ADD;
      bus.ex_ready  = 1'b0;
      bus.ex_result = 16'h0000;
      bus.br_req    = 1'b1;
      bus.br_cond   = 3'b001;
      #1;
      testsRun++;
      if (bus.br_wait !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL flush_enter_wait: got %b expected 1", bus.br_wait);
      end
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      testsRun++;
      if (bus.br_done !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL flush_no_done: got %b expected 0", bus.br_done);
      end
      @(negedge clk);
      clearInputs();
      @(posedge clk);
      #1;
      testsRun++;
      if (bus.br_done !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL flush_no_late_done: got %b expected 0", bus.br_done);
      end
      checkFlags("flush_flags_held", 3'b100);
      applyOp(OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b1);
      checkFlags("flush_blocks_commit", 3'b100);
   endtask

   task automatic test_uncond_reset();
      @(negedge clk);
      bus.ex_valid  = 1'b1;
      bus.ex_opcode = OP_SUB;
      bus.ex_ready  = 1'b0;
      bus.br_req    = 1'b1;
      bus.br_cond   = 3'b111;
      #1;
      testsRun++;
      if (bus.br_wait !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL uncond_no_wait: got %b expected 0", bus.br_wait);
      end
      @(posedge clk);
      #1;
      testsRun += 2;
      if (bus.br_done !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL uncond_done: got %b expected 1", bus.br_done);
      end
      if (bus.br_taken !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL uncond_taken: got %b expected 1", bus.br_taken);
      end
      @(negedge clk);
      bus.br_req = 1'b0;
      @(negedge clk);
      bus.br_req  = 1'b1;
      bus.br_cond = 3'b001;
      #1;
      testsRun++;
      if (bus.br_wait !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL eq_hazard_wait: got %b expected 1", bus.br_wait);
      end
      @(negedge clk);
      #1;
      testsRun++;
      if (bus.br_wait !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL eq_still_wait: got %b expected 1", bus.br_wait);
      end
      rst = 1'b1;
      #1;
      testsRun += 4;
      if (bus.br_wait !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL rst_mid_wait_br_wait: got %b expected 0", bus.br_wait);
      end
      if (bus.br_done !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL rst_mid_wait_br_done: got %b expected 0", bus.br_done);
      end
      if (bus.br_taken !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL rst_mid_wait_br_taken: got %b expected 0", bus.br_taken);
      end
      if (bus.flags !== 3'b000) begin
         testsFailed++;
         $display("[TB] FAIL rst_mid_wait_flags: got %b expected 000", bus.flags);
      end
      clearInputs();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      testsRun++;
      if (bus.br_done !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL rst_abandons_branch: got %b expected 0", bus.br_done);
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst         = 1'b1;
      clearInputs();
      test_reset();
      test_flag_update();
      test_conditions();
      test_multicycle();
      test_flush();
      test_uncond_reset();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/flag_branch_ctrl.md
Name: flag_branch_ctrl

Overview:
- Owns the architectural FLAG register (N, V, Z) of the 16-bit CPU.
- Decides per opcode which flags an EX-stage ALU result updates, and commits them.
- Sequences conditional-branch resolution for decode. When a branch's flags are not yet final, it holds decode and later reports taken/not-taken with a registered handshake.
- Sits between the EX-stage ALU/flag logic and the decode-stage branch unit.

Parameters:
- OPC_W, 4, opcode width.
- DATA_W, 16, ALU result width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX stage holds a live instruction.
- ex_opcode  in  OPC_W  EX instruction opcode.
- ex_result  in  DATA_W  ALU result.
- ex_ovfl  in  1  signed 16-bit overflow from ALU (ADD/SUB).
- ex_ready  in  1  ALU result final this cycle (low while a multi-cycle op is in progress).
- stall  in  1  pipeline stall; EX does not advance.
- flush  in  1  kill EX instruction and any in-progress branch.
- br_req  in  1  decode presents a branch; held high until br_done.
- br_cond  in  3  condition code; stable while br_req high.
- br_wait  out  1  stall request to decode.
- br_done  out  1  one-cycle pulse, branch resolved.
- br_taken  out  1  resolution result; valid when br_done=1.
- flags  out  3  architectural flags: [2]=N, [1]=V, [0]=Z.

Behaviour:
- Reset: flags=3'b000, state=IDLE, br_wait=0, br_done=0, br_taken=0. Reset is async assert; reset mid-branch abandons the branch with no br_done.
- Opcode decode (sets_flags):
  - ADD=0000 and SUB=0001 update N, V, Z.
  - XOR=0010, SLL=0100, SRA=0101, ROR=0110 update Z only.
  - All other opcodes, including RED=0011 and PADDSB=0111, update nothing.
- Flag values:
  - Z = (ex_result == 0).
  - N = ex_result[15].
  - V = ex_ovfl.
  - Non-updated bits keep their stored value.
- Commit: the FLAG register updates on the clock edge where ex_valid & ex_ready & sets_flags & !stall & !flush. flags_next is that update, or the held value otherwise.
- Condition evaluation (F = N,V,Z):
  - 000 NEQ: !Z.
  - 001 EQ: Z.
  - 010 GT: !Z & !N.
  - 011 LT: N.
  - 100 GTE: Z | !N.
  - 101 LTE: N | Z.
  - 110 OVFL: V.
  - 111 UNCOND: 1.
- Hazard (bypass build) = ex_valid & sets_flags & (!ex_ready | stall).
- FSM states:
  - IDLE:
    - br_req & !flush & !hazard: evaluate br_cond on flags_next. Register br_taken, pulse br_done next cycle, go to DONE.
    - br_req & hazard: br_wait=1 combinationally this cycle, go to WAIT.
  - WAIT:
    - br_wait=1.
    - When hazard clears: evaluate on flags_next and go to DONE.
    - flush → IDLE, no br_done.
  - DONE:
    - br_done=1 for exactly one cycle, br_wait=0, go to IDLE.
    - A br_req still high in DONE is ignored (decode drops it the same cycle).
- UNCOND never waits: resolves in IDLE regardless of hazard.
- Latency:
  - No hazard: br_done 1 cycle after br_req.
  - Hazard: br_done 1 cycle after the cycle the hazard clears.
- flush in the same cycle as a commit blocks the commit. flush in DONE does not cancel the already-registered pulse.
- stall holds the FSM in WAIT. stall does not affect IDLE→DONE when there is no hazard.

Optional Feature:
- FLAG_BYPASS_EN
- Defined: behaviour as above; a branch sees the flag update committing in the same cycle via flags_next.
- Undefined:
  - hazard = ex_valid & sets_flags (ready or not).
  - Evaluation uses the stored flags only.
  - A branch behind any flag-setting EX instruction spends ≥1 WAIT cycle and resolves on the cycle after the commit.

Test Plan:
- Reset, then ADD with result 0x0000, ovfl=0 → flags=3'b001. Then SUB with result 0x8000, ovfl=1 → flags=3'b110.
- flags=3'b001, then XOR with result 0x1234 → flags=3'b000 (N, V held). RED with result 0 → flags unchanged.
- br_req EQ with flags Z=1, no EX op → br_done pulse 1 cycle later, br_taken=1, br_wait never high.
- ADD multi-cycle (ex_ready low 3 cycles, final result 0xFFFF) with br_req LT → br_wait high 3 cycles, then br_done with br_taken=1 (bypass); without FLAG_BYPASS_EN, br_wait high 4 cycles.
- In WAIT, assert flush → state IDLE, no br_done, flags unchanged; also ADD result 0 with flush → Z not set.
- br_req UNCOND while a multi-cycle SUB is pending → br_done 1 cycle later, br_taken=1; assert rst mid-WAIT → all outputs 0 immediately.
